// File: rtl/pll_lock_reset_ctrl.sv
// PLL power-up / lock-qualification sequencer running on the PLL reference clock.
// Define PLL_RELOCK_POWERCYCLE_EN to power-cycle the PLL on every RUN lock loss instead of waiting for relock.
module pll_lock_reset_ctrl #(
    parameter int PD_HOLD_CYCLES      = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 PLL_LOCK,
    input  logic                 RESTART,
    output logic                 PLL_POWERDOWN_N,
    output logic                 FABRIC_RESET,
    output logic                 LOCK_STABLE,
    output logic [CNT_WIDTH-1:0] LOCK_LOSS_CNT,
    output logic [CNT_WIDTH-1:0] RETRY_CNT,
    output logic [1:0]           STATE
);

    localparam int MAX_AB  = (PD_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? PD_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC);

    localparam logic [CYC_W-1:0] PD_LAST      = CYC_W'(PD_HOLD_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PD          = 2'd0,
        ST_WAIT_LOCK   = 2'd1,
        ST_STABLE_WAIT = 2'd2,
        ST_RUN         = 2'd3
    } state_t;

`ifdef PLL_RELOCK_POWERCYCLE_EN
    localparam state_t LOSS_NEXT = ST_PD;
`else
    localparam state_t LOSS_NEXT = ST_WAIT_LOCK;
`endif

    state_t               state;
    state_t               state_next;
    logic [CYC_W-1:0]     cyc;
    logic                 lock_meta;
    logic                 lock_s;
    logic                 retry_inc;
    logic                 loss_inc;
    logic                 pd_n;
    logic                 frst;
    logic                 lstable;
    logic [CNT_WIDTH-1:0] loss_cnt;
    logic [CNT_WIDTH-1:0] retry_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Outputs are registered from the next state so they change on the same edge as STATE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_PD;
            cyc       <= '0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            pd_n      <= 1'b0;
            frst      <= 1'b1;
            lstable   <= 1'b0;
            loss_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
            state     <= state_next;
            if (state_next != state) begin
                cyc <= '0;
            end else if (state != ST_RUN) begin
                cyc <= cyc + CYC_W'(1);
            end
            pd_n    <= (state_next != ST_PD);
            frst    <= (state_next != ST_RUN);
            lstable <= (state_next == ST_RUN);
            if (retry_inc) begin
                retry_cnt <= sat_inc(retry_cnt);
            end
            if (loss_inc) begin
                loss_cnt <= sat_inc(loss_cnt);
            end
        end
    end

    always_comb begin
        state_next = state;
        retry_inc  = 1'b0;
        loss_inc   = 1'b0;
        case (state)
            ST_PD: begin
                if (cyc == PD_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (RESTART) begin
                    state_next = ST_PD;
                end else if (lock_s) begin
                    state_next = ST_STABLE_WAIT;
                end else if (cyc == TIMEOUT_LAST) begin
                    state_next = ST_PD;
                    retry_inc  = 1'b1;
                end
            end
            ST_STABLE_WAIT: begin
                if (RESTART) begin
                    state_next = ST_PD;
                end else if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cyc == STABLE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A lock loss is counted even when a coincident RESTART decides the next state.
                loss_inc = !lock_s;
                if (RESTART) begin
                    state_next = ST_PD;
                end else if (!lock_s) begin
                    state_next = LOSS_NEXT;
                end
            end
            default: begin
                state_next = ST_PD;
            end
        endcase
    end

    assign PLL_POWERDOWN_N = pd_n;
    assign FABRIC_RESET    = frst;
    assign LOCK_STABLE     = lstable;
    assign LOCK_LOSS_CNT   = loss_cnt;
    assign RETRY_CNT       = retry_cnt;
    assign STATE           = state;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Scoreboard bench for pll_lock_reset_ctrl: stimulus queues expected state transitions
// (with dwell time and outputs); a negedge monitor pops them whenever STATE changes.
`timescale 1ns/1ps
module tb_pll_lock_reset_ctrl;

    localparam int PD = 8;
    localparam int TO = 100;
    localparam int ST = 16;
    localparam int CW = 4;

    logic          CLK      = 1'b0;
    logic          RESET    = 1'b0;
    logic          PLL_LOCK = 1'b0;
    logic          RESTART  = 1'b0;
    logic          PLL_POWERDOWN_N;
    logic          FABRIC_RESET;
    logic          LOCK_STABLE;
    logic [CW-1:0] LOCK_LOSS_CNT;
    logic [CW-1:0] RETRY_CNT;
    logic [1:0]    STATE;

    typedef struct {
        int state;
        int loss;
        int retry;
        int dwell;
    } exp_t;

    exp_t exp_q[$];
    exp_t rst_q[$];
    exp_t mon_e;
    exp_t rst_e;
    int   compared   = 0;
    int   mismatched = 0;
    logic [1:0] prev_state = 2'd0;
    int   dwell = 0;

    always #5 CLK = ~CLK;

    pll_lock_reset_ctrl #(
        .PD_HOLD_CYCLES     (PD),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (ST),
        .CNT_WIDTH          (CW)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .PLL_LOCK       (PLL_LOCK),
        .RESTART        (RESTART),
        .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
        .FABRIC_RESET   (FABRIC_RESET),
        .LOCK_STABLE    (LOCK_STABLE),
        .LOCK_LOSS_CNT  (LOCK_LOSS_CNT),
        .RETRY_CNT      (RETRY_CNT),
        .STATE          (STATE)
    );

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_tr(input int s, input int loss, input int retry, input int dw);
        exp_t x;
        x.state = s;
        x.loss  = loss;
        x.retry = retry;
        x.dwell = dw;
        exp_q.push_back(x);
    endtask

    task automatic expect_rst();
        exp_t x;
        x.state = 0;
        x.loss  = 0;
        x.retry = 0;
        x.dwell = 0;
        rst_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_state(input int s, input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK);
            #1;
            if (int'(STATE) == s) return;
        end
        compared++;
        mismatched++;
        $display("FAIL %s: state %0d, expected %0d within 2000 cycles", tag, STATE, s);
    endtask

    task automatic wait_leave(input int s, input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK);
            #1;
            if (int'(STATE) != s) return;
        end
        compared++;
        mismatched++;
        $display("FAIL %s: state stuck at %0d within 2000 cycles", tag, s);
    endtask

    // Transition monitor plus per-cycle output/state consistency.
    always @(negedge CLK) begin
        if (RESET) begin
            prev_state = STATE;
            dwell      = 0;
        end else begin
            dwell++;
            chk("pdn_vs_state",    int'(PLL_POWERDOWN_N), int'(STATE != 2'd0));
            chk("frst_vs_state",   int'(FABRIC_RESET),    int'(STATE != 2'd3));
            chk("lstable_vs_state", int'(LOCK_STABLE),    int'(STATE == 2'd3));
            if (STATE !== prev_state) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_transition: got %0d -> %0d, expected no transition", prev_state, STATE);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tr_state", int'(STATE), mon_e.state);
                    chk("tr_dwell", dwell, mon_e.dwell);
                    chk("tr_pdn",   int'(PLL_POWERDOWN_N), int'(mon_e.state != 0));
                    chk("tr_frst",  int'(FABRIC_RESET),    int'(mon_e.state != 3));
                    chk("tr_lstable", int'(LOCK_STABLE),   int'(mon_e.state == 3));
                    chk("tr_loss",  int'(LOCK_LOSS_CNT),   mon_e.loss);
                    chk("tr_retry", int'(RETRY_CNT),       mon_e.retry);
                end
                prev_state = STATE;
                dwell      = 0;
            end
        end
    end

    // Reset monitor: asynchronous reset must take effect without a clock edge.
    always @(posedge RESET) begin
        #1;
        if (rst_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_reset: got reset at %0t, expected none", $time);
        end else begin
            rst_e = rst_q.pop_front();
            chk("rst_state", int'(STATE),           rst_e.state);
            chk("rst_pdn",   int'(PLL_POWERDOWN_N), 0);
            chk("rst_frst",  int'(FABRIC_RESET),    1);
            chk("rst_lstable", int'(LOCK_STABLE),   0);
            chk("rst_loss",  int'(LOCK_LOSS_CNT),   rst_e.loss);
            chk("rst_retry", int'(RETRY_CNT),       rst_e.retry);
        end
    end

    initial begin
        // Power-up with lock held high.
        PLL_LOCK = 1'b1;
        expect_rst();
        #1 RESET = 1'b1;
        expect_tr(1, 0, 0, PD);
        expect_tr(2, 0, 0, 1);
        expect_tr(3, 0, 0, ST);
        repeat (3) @(negedge CLK);
        #1 RESET = 1'b0;
        wait_state(3, "powerup_run");

        // Lock loss in RUN: synchronizer makes it visible on the third edge.
`ifdef PLL_RELOCK_POWERCYCLE_EN
        expect_tr(0, 1, 0, 7);
        expect_tr(1, 1, 0, PD);
        expect_tr(2, 1, 0, 1);
        expect_tr(3, 1, 0, ST);
`else
        expect_tr(1, 1, 0, 7);
        expect_tr(2, 1, 0, 3);
        expect_tr(3, 1, 0, ST);
`endif
        step(4);
        PLL_LOCK = 1'b0;
        wait_leave(3, "lockloss_leave_run");
        PLL_LOCK = 1'b1;
        wait_state(3, "lockloss_back_to_run");

        // RESTART alone in RUN, then a 3-cycle lock glitch at STABLE_WAIT cycle 10.
        expect_tr(0, 1, 0, 3);
        expect_tr(1, 1, 0, PD);
        expect_tr(2, 1, 0, 1);
        expect_tr(1, 1, 0, 13);
        expect_tr(2, 1, 0, 3);
        expect_tr(3, 1, 0, ST);
        step(2);
        RESTART = 1'b1;
        step(1);
        RESTART = 1'b0;
        wait_state(2, "restart_to_stable");
        step(10);
        PLL_LOCK = 1'b0;
        step(3);
        PLL_LOCK = 1'b1;
        wait_state(3, "glitch_back_to_run");

        // RESTART coincident with a lock loss: PD wins, loss still counted.
        expect_tr(0, 2, 0, 7);
        expect_tr(1, 2, 0, PD);
        expect_tr(2, 2, 0, 1);
        expect_tr(3, 2, 0, ST);
        step(4);
        PLL_LOCK = 1'b0;
        step(2);
        RESTART = 1'b1;
        step(1);
        RESTART  = 1'b0;
        PLL_LOCK = 1'b1;
        wait_state(3, "coincident_back_to_run");

        // Asynchronous reset in the middle of STABLE_WAIT, away from any edge.
        expect_tr(0, 2, 0, 3);
        expect_tr(1, 2, 0, PD);
        expect_tr(2, 2, 0, 1);
        step(2);
        RESTART = 1'b1;
        step(1);
        RESTART = 1'b0;
        wait_state(2, "prereset_stable");
        step(5);
        #2;
        expect_rst();
        RESET    = 1'b1;
        PLL_LOCK = 1'b0;

        // Lock never arrives: retry every TO cycles, counter saturates at 15.
        expect_tr(1, 0, 0, PD);
        for (int i = 1; i <= 17; i++) begin
            expect_tr(0, 0, (i > 15) ? 15 : i, TO);
            expect_tr(1, 0, (i > 15) ? 15 : i, PD);
        end
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge CLK);
            #1;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d transitions still pending, expected 0", exp_q.size());
        end
        chk("rst_q_drained", rst_q.size(), 0);
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
